fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, reset PC and FSM encoding for the fetch stage
package fetch_stage_pkg;
    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned INST_W_DEF = 32;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 64'h0;

    typedef logic [ADDR_W_DEF-1:0] InstAddrBus;
    typedef logic [INST_W_DEF-1:0] InstBus;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bus
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with flush > hold > load priority
module if_id_reg #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_valid
);
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= '0;
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_pc    <= i_pc;
                r_inst  <= i_inst;
                r_valid <= 1'b1;
            end else begin
                // no new instruction this cycle: present a bubble
                r_valid <= 1'b0;
            end
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with redirect kill and stall buffer
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    fetch_stage_if.master     imem,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);
    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_buf_pc;
    logic [INST_W-1:0] r_buf_inst;
    logic              r_buf_valid;
    logic              r_kill;

    logic              w_req;
    logic              w_resp_load;
    logic              w_buf_load;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_pc;
    logic [INST_W-1:0] w_load_inst;

    // reset gates the request so nothing is issued while state is forced to IDLE
    assign w_req          = reset && (r_state == IDLE) && !pc_src && !stall;
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign w_resp_load = (r_state == WAIT) && imem.imem_rvalid && !r_kill && !stall && !pc_src;
    assign w_buf_load  = (r_state == HOLD) && r_buf_valid && !stall && !pc_src;
    assign w_load      = w_resp_load || w_buf_load;
    assign w_load_pc   = w_buf_load ? r_buf_pc   : r_fetch_pc;
    assign w_load_inst = w_buf_load ? r_buf_inst : imem.imem_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= '0;
            r_buf_pc    <= '0;
            r_buf_inst  <= '0;
            r_buf_valid <= 1'b0;
            r_kill      <= 1'b0;
        end else if (pc_src) begin
            r_pc        <= branch_target;
            r_buf_valid <= 1'b0;
            // a request still in flight must have its response swallowed later
            if ((r_state == WAIT) && !imem.imem_rvalid) begin
                r_kill  <= 1'b1;
                r_state <= WAIT;
            end else begin
                r_kill  <= 1'b0;
                r_state <= IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && imem.imem_gnt) begin
                        r_fetch_pc <= r_pc;
                        r_pc       <= r_pc + ADDR_W'(4);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= IDLE;
                        end else if (stall) begin
                            r_buf_pc    <= r_fetch_pc;
                            r_buf_inst  <= imem.imem_rdata;
                            r_buf_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clock   (clock),
        .reset   (reset),
        .i_flush (pc_src),
        .i_hold  (stall),
        .i_load  (w_load),
        .i_pc    (w_load_pc),
        .i_inst  (w_load_inst),
        .o_pc    (id_pc_o),
        .o_inst  (id_inst_o),
        .o_valid (id_valid_o)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scenario bench for fetch_stage with a latency-configurable memory model
module tb_fetch_stage;
    logic        clock;
    logic        reset;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        stall;
    logic [63:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 1;
    logic        use_fixed = 1'b0;
    logic [95:0] sb_q[$];

    fetch_stage_if #(.ADDR_W(64), .INST_W(32)) imem ();

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .imem          (imem),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // memory: grant seen before an edge, response mem_lat cycles later
    initial begin
        logic        g;
        logic [63:0] a;
        logic [63:0] paddr;
        int          cnt;
        cnt = 0;
        paddr = '0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        forever begin
            @(negedge clock);
            g = (imem.imem_req === 1'b1) && imem.imem_gnt && reset;
            a = imem.imem_addr;
            @(posedge clock);
            #1;
            imem.imem_rvalid = 1'b0;
            if (g) begin
                paddr = a;
                cnt   = mem_lat;
            end
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem.imem_rvalid = 1'b1;
                    imem.imem_rdata  = use_fixed ? 32'h8B02_0020 : inst_of(paddr);
                end
            end
        end
    end

    // scoreboard consumer: a new IF/ID load is valid after an unstalled edge
    initial begin
        logic        st_e;
        logic        rs_e;
        logic [95:0] exp_e;
        forever begin
            @(posedge clock);
            st_e = stall;
            rs_e = reset;
            @(negedge clock);
            if (rs_e && !st_e && (id_valid_o === 1'b1)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: got pc=%h inst=%h want no load", id_pc_o, id_inst_o);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({id_pc_o, id_inst_o} !== exp_e)
                        begin errors++; $display("FAIL sb_load: got pc=%h inst=%h want pc=%h inst=%h", id_pc_o, id_inst_o, exp_e[95:32], exp_e[31:0]); end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0; pc_src = 1'b0; stall = 1'b0; branch_target = '0;
        imem.imem_gnt = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem.imem_addr); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
        checks++; if (id_pc_o !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc_o); end
        checks++; if (id_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", id_inst_o); end
    endtask

    task automatic test_sequential();
        logic exp_v[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) sb_q.push_back({64'(k * 4), inst_of(64'(k * 4))});
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin @(posedge clock); #1; imem.imem_gnt = 1'b0; end
            @(negedge clock);
            checks++; if (id_valid_o !== exp_v[c]) begin errors++; $display("FAIL seq_valid[%0d]: got %b want %b", c, id_valid_o, exp_v[c]); end
            if ((c % 2) == 0 && c < 6) begin
                checks++; if (imem.imem_addr !== 64'(c * 2)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", c, imem.imem_addr, 64'(c * 2)); end
            end
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL seq_drain: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_stall();
        use_fixed = 1'b1;
        sb_q.push_back({64'hC, 32'h8B02_0020});
        @(posedge clock); #1; imem.imem_gnt = 1'b1;
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'hC) begin errors++; $display("FAIL stall_req: got req=%b addr=%h want 1/c", imem.imem_req, imem.imem_addr); end
        @(posedge clock); #1; imem.imem_gnt = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            @(negedge clock);
            checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 0", i, id_valid_o); end
            checks++; if (id_pc_o !== 64'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 8", i, id_pc_o); end
            checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d]: got %b want 0", i, imem.imem_req); end
        end
        @(posedge clock); #1; stall = 1'b0;
        @(negedge clock);
        checks++; if (id_valid_o !== 1'b0 || imem.imem_req !== 1'b0) begin errors++; $display("FAIL hold_release: got valid=%b req=%b want 0/0", id_valid_o, imem.imem_req); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (id_valid_o !== 1'b1 || id_inst_o !== 32'h8B02_0020) begin errors++; $display("FAIL hold_load: got valid=%b inst=%h want 1/8b020020", id_valid_o, id_inst_o); end
        use_fixed = 1'b0;
    endtask

    task automatic test_branch_kill();
        mem_lat = 3;
        @(posedge clock); #1; imem.imem_gnt = 1'b1;
        @(posedge clock); #1; imem.imem_gnt = 1'b0; pc_src = 1'b1; branch_target = 64'h100;
        @(posedge clock); #1; pc_src = 1'b0;
        @(negedge clock);
        checks++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin errors++; $display("FAIL kill_flush: got valid=%b inst=%h want 0/0", id_valid_o, id_inst_o); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL kill_wait_req: got %b want 0", imem.imem_req); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL kill_resp_req: got %b want 0", imem.imem_req); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h100) begin errors++; $display("FAIL kill_redirect: got req=%b addr=%h want 1/100", imem.imem_req, imem.imem_addr); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL kill_drop: got %b want 0", id_valid_o); end
        mem_lat = 1;
    endtask

    task automatic test_same_cycle();
        @(posedge clock); #1; imem.imem_gnt = 1'b1;
        @(posedge clock); #1; imem.imem_gnt = 1'b0; pc_src = 1'b1; branch_target = 64'h200;
        @(negedge clock);
        checks++; if (imem.imem_rvalid !== 1'b1 || imem.imem_req !== 1'b0) begin errors++; $display("FAIL same_setup: got rvalid=%b req=%b want 1/0", imem.imem_rvalid, imem.imem_req); end
        @(posedge clock); #1; pc_src = 1'b0;
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h200) begin errors++; $display("FAIL same_redirect: got req=%b addr=%h want 1/200", imem.imem_req, imem.imem_addr); end
        checks++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin errors++; $display("FAIL same_drop: got valid=%b inst=%h want 0/0", id_valid_o, id_inst_o); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL same_late: got %b want 0", id_valid_o); end
    endtask

    task automatic test_wrap();
        @(posedge clock); #1; pc_src = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clock); #1; pc_src = 1'b0; imem.imem_gnt = 1'b1;
        sb_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, inst_of(64'hFFFF_FFFF_FFFF_FFFC)});
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top: got req=%b addr=%h want 1/fffffffffffffffc", imem.imem_req, imem.imem_addr); end
        @(posedge clock); #1; imem.imem_gnt = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (imem.imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem.imem_addr); end
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_load: got valid=%b pc=%h want 1/fffffffffffffffc", id_valid_o, id_pc_o); end
    endtask

    task automatic test_reset_mid_wait();
        mem_lat = 3;
        @(posedge clock); #1; imem.imem_gnt = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL mrst_req: got %b want 0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 64'h0) begin errors++; $display("FAIL mrst_pc: got %h want 0", imem.imem_addr); end
        checks++; if (id_valid_o !== 1'b0 || id_pc_o !== 64'h0 || id_inst_o !== 32'h0) begin errors++; $display("FAIL mrst_ifid: got valid=%b pc=%h inst=%h want all 0", id_valid_o, id_pc_o, id_inst_o); end
        @(posedge clock); #1;
        @(posedge clock); #1; reset = 1'b1; mem_lat = 1;
        sb_q.push_back({64'h0, inst_of(64'h0)});
        @(negedge clock);
        checks++; if (imem.imem_rvalid !== 1'b1 || id_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_stale: got rvalid=%b valid=%b want 1/0", imem.imem_rvalid, id_valid_o); end
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h0) begin errors++; $display("FAIL mrst_first: got req=%b addr=%h want 1/0", imem.imem_req, imem.imem_addr); end
        @(posedge clock); #1;
        @(posedge clock); #1; imem.imem_gnt = 1'b0;
        @(negedge clock);
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 64'h0) begin errors++; $display("FAIL mrst_load: got valid=%b pc=%h want 1/0", id_valid_o, id_pc_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_kill();
        test_same_cycle();
        test_wrap();
        test_reset_mid_wait();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending want 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
